// File: rtl/lc3b_line_arbiter.sv
// lc3b_line_arbiter: N-channel cache-line arbiter in front of one lower-level memory port.
// A single transaction is latched at grant and replayed downstream until mem_resp; a one-cycle
// DONE bubble returns the response and lets the winning client drop its request before the
// next arbitration.

// Per-channel request decode: any request, and the illegal read+write combination.
module lc3b_line_arbiter_ch (
    input  logic i_read,
    input  logic i_write,
    output logic o_req,
    output logic o_conflict
);
    assign o_req      = i_read | i_write;
    assign o_conflict = i_read & i_write;
endmodule

module lc3b_line_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter bit RR_MODE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           ch_read,
    input  logic [NUM_CH-1:0]           ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_address,
    input  logic [NUM_CH*LINE_W-1:0]    ch_wdata,
    output logic [NUM_CH-1:0]           ch_resp,
    output logic [LINE_W-1:0]           ch_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [LINE_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [$clog2(NUM_CH)-1:0]   grant_id,
    output logic                        proto_err
);
    localparam int ID_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_rdata;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [NUM_CH-1:0]   r_ch_resp;
    logic                r_proto_err;

    logic [NUM_CH-1:0]   w_req;
    logic [NUM_CH-1:0]   w_conf;
    logic                w_any;
    logic [ID_W-1:0]     w_win;
    logic [ID_W-1:0]     w_next_ptr;
    int                  w_idx;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LINE_W-1:0]   w_sel_wdata;
    logic                w_sel_write;

    // One decode instance per client channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        lc3b_line_arbiter_ch u_ch (
            .i_read     (ch_read[i]),
            .i_write    (ch_write[i]),
            .o_req      (w_req[i]),
            .o_conflict (w_conf[i])
        );
    end

    // Winner search: from rr_ptr with wrap in round-robin mode, from channel 0 in fixed priority.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = RR_MODE ? ((int'(r_rr_ptr) + i) % NUM_CH) : i;
            if (!w_any && w_req[w_idx]) begin
                w_any = 1'b1;
                w_win = ID_W'(w_idx);
            end
        end
    end

    // Pointer advances past the winner; explicit wrap keeps non-power-of-two counts correct.
    assign w_next_ptr  = (int'(w_win) == NUM_CH - 1) ? '0 : w_win + 1'b1;
    assign w_sel_addr  = ch_address[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = ch_wdata[int'(w_win)*LINE_W +: LINE_W];
    assign w_sel_write = ch_write[w_win];

    // Transaction FSM: latch at grant, replay downstream, pulse the client response once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ch_resp   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_ch_resp <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_BUSY;
                        r_grant     <= w_win;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        // Read+write together resolves to a write and flags the error.
                        r_mem_write <= w_sel_write;
                        r_mem_read  <= ~w_sel_write;
                        if (w_conf[w_win])
                            r_proto_err <= 1'b1;
                        if (RR_MODE)
                            r_rr_ptr <= w_next_ptr;
                    end
                end
                S_BUSY: begin
                    if (mem_resp) begin
                        // Write completions leave the shared read line untouched.
                        if (!r_mem_write)
                            r_rdata <= mem_rdata;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_ch_resp   <= NUM_CH'(1) << r_grant;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ch_resp     = r_ch_resp;
    assign ch_rdata    = r_rdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant;
    assign proto_err   = r_proto_err;

endmodule

// File: doc/lc3b_line_arbiter.md
Name: lc3b_line_arbiter

Overview:
- Parametrised N-channel cache-line arbiter between N upstream cache clients and one lower-level memory port (victim cache, L2 or physical memory).
- It is the next-generation replacement for the hard-wired two-client (instruction/data) arbitration inside the L1 complex.
- Adds configurable channel count, line and address width, round-robin or fixed-priority mode, a latched transaction, and a sticky protocol-error flag.

Parameters:
- NUM_CH, 2, number of client channels (2..8).
- ADDR_W, 16, address width.
- LINE_W, 128, cache-line width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority with channel 0 highest.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_read  in  NUM_CH  per-channel line read request, held until that channel's ch_resp.
- ch_write  in  NUM_CH  per-channel line write request, held until that channel's ch_resp.
- ch_address  in  NUM_CH*ADDR_W  flattened addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W  flattened write lines.
- ch_resp  out  NUM_CH  one-hot, one-cycle completion pulse.
- ch_rdata  out  LINE_W  read line, shared by all channels, valid while any ch_resp bit is high.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  LINE_W  downstream write line.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  LINE_W  downstream read line.
- busy  out  1  a transaction is in flight.
- grant_id  out  $clog2(NUM_CH)  channel currently or most recently granted.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; rr_ptr=0.
- Reset mid-transaction: mem_read/mem_write drop immediately; the in-flight transaction is abandoned.
- States:
  - IDLE: a channel is requesting when ch_read|ch_write is high for it. If any channel is requesting, select the winner, latch its channel id, op, address and wdata, and go to BUSY next edge. Otherwise stay in IDLE.
  - BUSY: mem_read/mem_write/mem_address/mem_wdata are driven from the latched registers only. Client inputs are ignored; withdrawing a request does not cancel the transaction. On mem_resp=1, capture mem_rdata into ch_rdata and go to DONE.
  - DONE (exactly 1 cycle): ch_resp[grant]=1, mem_read=mem_write=0. Then go to IDLE. This cycle is the bubble that lets the client drop its request before the next arbitration.
- Latency: request seen at edge k → mem_read/write high from cycle k+1 → mem_resp at cycle m → ch_resp high in cycle m+1.
  - Minimum request-to-resp time is 3 cycles when mem_resp comes in the first BUSY cycle.
- Round-robin (RR_MODE=1):
  - Search starts at rr_ptr and wraps modulo NUM_CH.
  - On grant, rr_ptr = (winner+1) mod NUM_CH; wrap from NUM_CH-1 goes to 0.
- Fixed priority (RR_MODE=0): lowest-index requesting channel wins; rr_ptr is unused.
- Read and write both high on one channel:
  - The write is performed.
  - proto_err is set when the grant is latched and stays 1 until reset.
- mem_resp while IDLE or DONE: ignored, no state change.
- busy = (state != IDLE).
- grant_id updates at grant and holds through IDLE.
- ch_rdata holds its last captured value until the next read completion. It is not updated on writes.

Test Plan:
- Single read: NUM_CH=2, ch_read[0]=1, address 0x1230; mem_resp after 4 cycles with rdata 0xDEAD…BEEF → mem_address=0x1230, mem_read held for 4 cycles, ch_resp=2'b01 for one cycle with ch_rdata=0xDEAD…BEEF, busy returns to 0.
- Round-robin fairness: NUM_CH=4, all four channels hold reads continuously, mem_resp is immediate, each channel drops its request for one cycle after its resp and then re-asserts → grant order 0,1,2,3,0; rr_ptr wraps 3→0.
- Fixed priority: RR_MODE=0, channels 1 and 2 request together → channel 1 is served first, then channel 2; channel 0 arriving during BUSY is served before channel 2.
- Request withdrawal: ch_write[1] drops in the second BUSY cycle → mem_write stays 1 until mem_resp, and ch_resp[1] still pulses.
- Protocol error: ch_read[0]=ch_write[0]=1 → mem_write=1, mem_read=0, proto_err=1 and still 1 after 10 further idle cycles.
- Async reset: assert rst_n=0 mid-BUSY → mem_read=0 immediately without waiting for a clock edge. After release, a stray mem_resp=1 produces no ch_resp, and the next request is granted to channel 0 (rr_ptr=0).
